// File: rtl/dut_clock_sequencer.sv
// Clock/reset sequencer for a Tiny Tapeout DUT: divided clock, reset hold,
// free-run, halt, single-step and restart, all registered off the board clock.
module dut_clock_sequencer #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 5000,
    parameter int RST_CYCLES  = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 run_req,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 restart_req,
    output logic                 clk_dut,
    output logic                 rst_dut_n,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int HOLD_WIDTH = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(RST_CYCLES);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_RUN  = 3'd1,
        S_HALT = 3'd2,
        S_STEP = 3'd3
    } seqState_t;

    seqState_t              state_q;
    logic                   clkDut_q;
    logic                   rstDutN_q;
    logic [DIV_WIDTH-1:0]   divCur_q;
    logic [DIV_WIDTH-1:0]   divPend_q;
    logic [DIV_WIDTH-1:0]   divCnt_q;
    logic [HOLD_WIDTH-1:0]  holdCnt_q;
    logic [CNT_WIDTH-1:0]   cycleCnt_q;
    logic                   haltPend_q;
    logic                   runPend_q;

    logic clkEn;
    logic atTerm;
    logic riseEv;
    logic fallEv;
    logic haltNow;

    assign clkEn  = (state_q != S_HALT);
    assign atTerm = (divCnt_q == divCur_q);
    assign riseEv = clkEn && atTerm && !clkDut_q;
    assign fallEv = clkEn && atTerm && clkDut_q;
    // A halt lands on the falling edge, or at once if the low phase has just begun.
    assign haltNow = (state_q == S_RUN) && (haltPend_q || halt_req) &&
                     (fallEv || (!clkDut_q && divCnt_q == '0));

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= S_HOLD;
            clkDut_q   <= 1'b0;
            rstDutN_q  <= 1'b0;
            divCur_q   <= DIV_WIDTH'(DEFAULT_DIV);
            divPend_q  <= DIV_WIDTH'(DEFAULT_DIV);
            divCnt_q   <= '0;
            holdCnt_q  <= '0;
            cycleCnt_q <= '0;
            haltPend_q <= 1'b0;
            runPend_q  <= 1'b0;
        end else begin
            if (div_load) begin
                divPend_q <= div_value;
            end

            if (restart_req) begin
                state_q    <= S_HOLD;
                clkDut_q   <= 1'b0;
                rstDutN_q  <= 1'b0;
                divCnt_q   <= '0;
                holdCnt_q  <= '0;
                cycleCnt_q <= '0;
                haltPend_q <= 1'b0;
                runPend_q  <= 1'b0;
            end else begin
                if (!clkEn) begin
                    divCnt_q <= '0;
                    clkDut_q <= 1'b0;
                end else if (atTerm) begin
                    divCnt_q <= '0;
                    clkDut_q <= !clkDut_q;
                end else begin
                    divCnt_q <= divCnt_q + 1'b1;
                end

                // New divider only takes effect at a period boundary so no runt phase is produced.
                if (fallEv || !clkEn) begin
                    divCur_q <= divPend_q;
                end

                case (state_q)
                    S_HOLD: begin
                        if (riseEv && holdCnt_q != HOLD_LAST) begin
                            holdCnt_q <= holdCnt_q + 1'b1;
                        end
                        if (fallEv && holdCnt_q == HOLD_LAST) begin
                            rstDutN_q  <= 1'b1;
                            cycleCnt_q <= '0;
                            state_q    <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (haltNow) begin
                            state_q    <= S_HALT;
                            clkDut_q   <= 1'b0;
                            divCnt_q   <= '0;
                            haltPend_q <= 1'b0;
                        end else begin
                            if (halt_req) begin
                                haltPend_q <= 1'b1;
                            end
                            if (riseEv) begin
                                cycleCnt_q <= cycleCnt_q + 1'b1;
                            end
                        end
                    end
                    S_HALT: begin
                        runPend_q <= 1'b0;
                        if (step_req) begin
                            state_q <= S_STEP;
                        end else if (run_req) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_STEP: begin
                        if (halt_req) begin
                            runPend_q <= 1'b0;
                        end else if (run_req) begin
                            runPend_q <= 1'b1;
                        end
                        if (riseEv) begin
                            cycleCnt_q <= cycleCnt_q + 1'b1;
                        end
                        if (fallEv) begin
                            state_q   <= (runPend_q || (run_req && !halt_req)) ? S_RUN : S_HALT;
                            runPend_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_HOLD;
                    end
                endcase
            end
        end
    end

    assign clk_dut     = clkDut_q;
    assign rst_dut_n   = rstDutN_q;
    assign state       = state_q;
    assign cycle_count = cycleCnt_q;

endmodule
